mouse_register_writer: RTL and testbench
========================================

// Module: mouse_register_writer
// PURPOSE
// - Host-side writer for the Kempston mouse CPLD register file.
// - Accumulates relative motion, wheel and button events into absolute X/Y/KEY bytes.
// - Writes each changed byte onto the shared 8-bit data bus, then pulses that register's strobe (MX/MY/MKEY).
// - The CPLD latches data on the strobe rising edge. Replaces the bit-banged ATmega firmware path.
// PARAMETERS
// - SETUP_CYCLES  4  cycles DO is stable, strobe low, before strobe rises (min 1)
// - PULSE_CYCLES  4  cycles strobe high (min 1)
// - HOLD_CYCLES   4  cycles DO held, strobe low, after strobe falls (min 1)
// PORTS
// - CLK         in   1  system clock; all logic on rising edge
// - RESET       in   1  synchronous, active-high reset
// - MOVE_VALID  in   1  one-cycle event strobe; inputs below sampled when high
// - DX          in   9  signed two's-complement X delta (+ = right)
// - DY          in   9  signed two's-complement Y delta (+ = up)
// - DWHEEL      in   4  signed wheel delta
// - BTN         in   3  {middle,right,left}, 1 = pressed
// - DO          out  8  data to CPLD DI bus
// - MX          out  1  X register write strobe
// - MY          out  1  Y register write strobe
// - MKEY        out  1  button/wheel register write strobe
// - BUSY        out  1  high while a write sequence is in progress
// BEHAVIOUR
// - Reset values: DO=8'hFF; MX/MY/MKEY/BUSY=0; x_acc=y_acc=8'h00; wheel_acc=4'hF; btn_q=3'b000.
//   After reset all three dirty flags are set.
// - Accumulation on MOVE_VALID, same cycle, never stalled:
//   - x_acc += DX[7:0], y_acc += DY[7:0], modulo 256; wrap is silent, no saturation.
//   - wheel_acc += DWHEEL, modulo 16. btn_q <= BTN.
// - Dirty flags:
//   - x_dirty set when x_acc changes; y_dirty and key_dirty likewise.
//   - A zero delta does not set the flag. key_dirty sets on any button or wheel change.
// - KEY byte = {wheel_acc, 1'b1, ~btn_q[2], ~btn_q[1], ~btn_q[0]}; buttons are active-low on the bus.
// - FSM states: IDLE, SETUP, PULSE, HOLD; one down-counter; register pointer sel in {X,Y,KEY}.
// - IDLE:
//   - Selects the first dirty register in priority X > Y > KEY.
//   - Next edge: DO <= snapshot of that byte, its dirty flag cleared, go SETUP.
//   - BUSY=1 from that edge onward.
// - SETUP (SETUP_CYCLES) -> PULSE: the selected strobe is high for exactly PULSE_CYCLES cycles.
// - HOLD (HOLD_CYCLES): next dirty register goes straight to SETUP with a new snapshot; none goes to IDLE with BUSY=0.
// - Timing:
//   - One byte write is SETUP+PULSE+HOLD cycles (12 at defaults).
//   - A write starts 1 cycle after dirty is seen in IDLE.
// - DO changes only on SETUP entry. DO holds its value through IDLE.
// - At most one strobe is high at any time. Strobes are registered outputs, glitch-free.
// - Update during a write: the snapshot on DO is unaffected.
//   - The register's dirty flag re-sets, so the byte is rewritten later.
//   - Set beats clear when a MOVE_VALID update coincides with the snapshot-clear edge.
// - Reset mid-sequence: strobe drops the same edge, FSM returns to IDLE, values per reset list; CPLD keeps its old byte.
// CONFIGURATION
// - MOUSE_WHEEL_EN defined: wheel accumulates as above.
// - MOUSE_WHEEL_EN undefined: DWHEEL is ignored, KEY[7:4] is constant 4'b1111, and wheel logic is not synthesised.
// TESTING
// - Reset release, no events:
//   - Writes X=00, Y=00, KEY=FF in order.
//   - Strobes rise at cycles 5, 17, 29 after the first non-reset edge.
//   - BUSY falls at cycle 37.
// - After idle, DX=+5: one write X=05 only. MX high 4 cycles; DO=05 is stable 4 cycles before and after MX.
// - x_acc=FE, DX=+3 -> X written 01 (wrap).
//   - y_acc=00, DY=-1 (9'h1FF) -> Y written FF.
// - BTN=3'b001 with wheel +2 from F -> KEY=0x1E; MOUSE_WHEEL_EN undefined -> KEY=0xFE.
// - DX=+1 during X's PULSE (DO=05):
//   - DO stays 05 through HOLD.
//   - X is rewritten as 06 after any pending Y/KEY writes.
// - RESET asserted while MY high -> MY=0 next edge; DO=FF; full reset sequence restarts on release.

Source files
------------

// File: rtl/mouse_register_writer.sv
// Host-side writer for the Kempston mouse CPLD: accumulates motion/wheel/buttons and writes changed X/Y/KEY bytes.
// Optional wheel accumulation is enabled with `define MOUSE_WHEEL_EN.
//
// state | meaning
// IDLE  | no write pending, DO holds last byte, BUSY low
// SETUP | DO carries snapshot, strobe low, counting setup time
// PULSE | selected strobe high
// HOLD  | strobe low, DO held; then next dirty register or IDLE
module mouse_register_writer #(
    parameter int SETUP_CYCLES = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MOVE_VALID,
    input  logic [8:0] DX,
    input  logic [8:0] DY,
    input  logic [3:0] DWHEEL,
    input  logic [2:0] BTN,
    output logic [7:0] DO,
    output logic       MX,
    output logic       MY,
    output logic       MKEY,
    output logic       BUSY
);

    localparam int CNT_MAX = (SETUP_CYCLES > PULSE_CYCLES)
                             ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                             : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int CW = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} state_t;
    typedef enum logic [1:0] {SEL_X, SEL_Y, SEL_KEY} sel_t;

    state_t        state, state_d;
    sel_t          sel, sel_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          snap;

    logic [7:0] x_acc, y_acc;
    logic [2:0] btn_q;
    logic [3:0] wheel_nib;
    logic       wheel_evt;
    logic [2:0] dirty, dirty_set, dirty_clr;

    logic [7:0] do_d, key_byte;
    logic       mx_d, my_d, mkey_d, busy_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_acc <= 8'h00;
            y_acc <= 8'h00;
            btn_q <= 3'b000;
        end else if (MOVE_VALID) begin
            x_acc <= x_acc + DX[7:0];
            y_acc <= y_acc + DY[7:0];
            btn_q <= BTN;
        end
    end

    // Only the low byte of the 9-bit deltas matters for modulo-256 accumulation.
    logic unused_inputs;
`ifdef MOUSE_WHEEL_EN
    logic [3:0] wheel_acc;

    always_ff @(posedge CLK) begin
        if (RESET)
            wheel_acc <= 4'hF;
        else if (MOVE_VALID)
            wheel_acc <= wheel_acc + DWHEEL;
    end

    assign wheel_nib     = wheel_acc;
    assign wheel_evt     = MOVE_VALID && (DWHEEL != 4'h0);
    assign unused_inputs = ^{DX[8], DY[8]};
`else
    assign wheel_nib     = 4'hF;
    assign wheel_evt     = 1'b0;
    assign unused_inputs = ^{DX[8], DY[8], DWHEEL};
`endif

    assign key_byte  = {wheel_nib, 1'b1, ~btn_q};
    assign dirty_set = {MOVE_VALID && ((BTN != btn_q) || wheel_evt),
                        MOVE_VALID && (DY[7:0] != 8'h00),
                        MOVE_VALID && (DX[7:0] != 8'h00)};

    // First dirty register at or after 'start', wrapping X -> Y -> KEY -> X.
    function automatic sel_t pick(input logic [2:0] d, input sel_t start);
        sel_t r;
        int   k;
        r = start;
        for (int i = 2; i >= 0; i--) begin
            k = (int'(start) + i) % 3;
            if (d[k]) r = sel_t'(k[1:0]);
        end
        return r;
    endfunction

    function automatic sel_t sel_after(input sel_t s);
        return (s == SEL_KEY) ? SEL_X : sel_t'(s + 2'd1);
    endfunction

    always_comb begin
        state_d = state;
        sel_d   = sel;
        cnt_d   = cnt;
        snap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|dirty) begin
                    state_d = ST_SETUP;
                    sel_d   = pick(dirty, SEL_X);
                    cnt_d   = CW'(SETUP_CYCLES - 1);
                    snap    = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = CW'(PULSE_CYCLES - 1);
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt != '0) begin
                    cnt_d = cnt - 1'b1;
                end else if (|dirty) begin
                    state_d = ST_SETUP;
                    sel_d   = pick(dirty, sel_after(sel));
                    cnt_d   = CW'(SETUP_CYCLES - 1);
                    snap    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, so strobes come straight from flops.
    always_comb begin
        do_d      = DO;
        dirty_clr = 3'b000;
        if (snap) begin
            case (sel_d)
                SEL_X:   begin do_d = x_acc;    dirty_clr = 3'b001; end
                SEL_Y:   begin do_d = y_acc;    dirty_clr = 3'b010; end
                default: begin do_d = key_byte; dirty_clr = 3'b100; end
            endcase
        end
        mx_d   = (state_d == ST_PULSE) && (sel_d == SEL_X);
        my_d   = (state_d == ST_PULSE) && (sel_d == SEL_Y);
        mkey_d = (state_d == ST_PULSE) && (sel_d == SEL_KEY);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            sel   <= SEL_X;
            cnt   <= '0;
            dirty <= 3'b111;
            DO    <= 8'hFF;
            MX    <= 1'b0;
            MY    <= 1'b0;
            MKEY  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            cnt   <= cnt_d;
            dirty <= (dirty & ~dirty_clr) | dirty_set;
            DO    <= do_d;
            MX    <= mx_d;
            MY    <= my_d;
            MKEY  <= mkey_d;
            BUSY  <= busy_d;
        end
    end

endmodule

// File: tb/tb_mouse_register_writer.sv
// Self-checking bench for mouse_register_writer: directed bus-timing scenarios plus a randomized run
// scored against an accumulator model and recorded per-cycle bus history.
module tb_mouse_register_writer;
    localparam int DEPTH = 8192;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       MOVE_VALID = 1'b0;
    logic [8:0] DX = '0;
    logic [8:0] DY = '0;
    logic [3:0] DWHEEL = '0;
    logic [2:0] BTN = '0;
    logic [7:0] DO;
    logic       MX, MY, MKEY, BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mouse_register_writer dut (
        .CLK(CLK), .RESET(RESET), .MOVE_VALID(MOVE_VALID),
        .DX(DX), .DY(DY), .DWHEEL(DWHEEL), .BTN(BTN),
        .DO(DO), .MX(MX), .MY(MY), .MKEY(MKEY), .BUSY(BUSY)
    );

    // Reference: absolute register contents after each edge.
    int         edge_cnt = 0;
    logic [7:0] m_x = 8'h00, m_y = 8'h00;
    logic [3:0] m_w = 4'hF;
    logic [2:0] m_b = 3'b000;

    always @(posedge CLK) begin
        edge_cnt <= edge_cnt + 1;
        if (RESET) begin
            m_x <= 8'h00; m_y <= 8'h00; m_w <= 4'hF; m_b <= 3'b000;
        end else if (MOVE_VALID) begin
            m_x <= m_x + DX[7:0];
            m_y <= m_y + DY[7:0];
`ifdef MOUSE_WHEEL_EN
            m_w <= m_w + DWHEEL;
`endif
            m_b <= BTN;
        end
    end

    function automatic logic [7:0] key_of(input logic [3:0] w, input logic [2:0] b);
        return {w, 1'b1, ~b};
    endfunction

    // History index k holds what was visible after edge k.
    logic [7:0] h_do [DEPTH];
    logic [7:0] h_x  [DEPTH];
    logic [7:0] h_y  [DEPTH];
    logic [7:0] h_key[DEPTH];
    logic [2:0] h_st [DEPTH];
    logic       h_busy[DEPTH];

    always @(negedge CLK) begin
        if (edge_cnt < DEPTH) begin
            h_do[edge_cnt]   <= DO;
            h_st[edge_cnt]   <= {MKEY, MY, MX};
            h_busy[edge_cnt] <= BUSY;
            h_x[edge_cnt]    <= m_x;
            h_y[edge_cnt]    <= m_y;
            h_key[edge_cnt]  <= key_of(m_w, m_b);
        end
    end

    function automatic int find_rise(input int w, input int from, input int to);
        for (int k = from; k <= to; k++)
            if (k > 0 && k < DEPTH && h_st[k][w] && !h_st[k-1][w]) return k;
        return -1;
    endfunction

    function automatic int count_rises(input int w, input int from, input int to);
        int n = 0;
        for (int k = from; k <= to; k++)
            if (k > 0 && k < DEPTH && h_st[k][w] && !h_st[k-1][w]) n++;
        return n;
    endfunction

    function automatic int pulse_width(input int w, input int r);
        int n = 0;
        for (int k = r; k < r + 12 && k >= 0 && k < DEPTH; k++) begin
            if (!h_st[k][w]) break;
            n++;
        end
        return n;
    endfunction

    // Samples from snapshot edge through end of hold that show the same byte as at the rise.
    function automatic int stable_span(input int r);
        int n = 0;
        for (int k = r - 4; k <= r + 7; k++)
            if (k >= 0 && k < DEPTH && h_do[k] === h_do[r]) n++;
        return n;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic move(input logic [8:0] dx, input logic [8:0] dy,
                        input logic [3:0] dw, input logic [2:0] b);
        MOVE_VALID = 1'b1; DX = dx; DY = dy; DWHEEL = dw; BTN = b;
        step(1);
        MOVE_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        step(2);
        for (int i = 0; i < budget; i++) begin
            if (BUSY === 1'b0) begin ok = 1'b1; break; end
            step(1);
        end
        step(2);
    endtask

    task automatic restart();
        bit ok;
        RESET = 1'b1; MOVE_VALID = 1'b0;
        step(2);
        RESET = 1'b0;
        wait_idle(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL restart_idle: busy after budget, required idle"); end
    endtask

    task automatic test_reset();
        int e, k;
        step(3);
        n_checks++;
        if ({DO, MKEY, MY, MX, BUSY} !== {8'hFF, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_state: DO=%h strb=%b busy=%b, required DO=ff strb=000 busy=0", DO, {MKEY, MY, MX}, BUSY);
        end
        RESET = 1'b0;
        e = edge_cnt + 1;
        step(45);
        n_checks++;
        if (find_rise(0, e, e + 40) !== e + 4) begin
            n_fail++; $display("FAIL reset_mx_rise: at %0d, required %0d", find_rise(0, e, e + 40), e + 4);
        end
        n_checks++;
        if (find_rise(1, e, e + 40) !== e + 16) begin
            n_fail++; $display("FAIL reset_my_rise: at %0d, required %0d", find_rise(1, e, e + 40), e + 16);
        end
        n_checks++;
        if (find_rise(2, e, e + 40) !== e + 28) begin
            n_fail++; $display("FAIL reset_mkey_rise: at %0d, required %0d", find_rise(2, e, e + 40), e + 28);
        end
        n_checks++;
        if ({h_do[e + 4], h_do[e + 16], h_do[e + 28]} !== {8'h00, 8'h00, 8'hFF}) begin
            n_fail++;
            $display("FAIL reset_bytes: X=%h Y=%h KEY=%h, required 00 00 ff", h_do[e + 4], h_do[e + 16], h_do[e + 28]);
        end
        k = e;
        while (k < e + 44 && h_busy[k]) k++;
        n_checks++;
        if (h_busy[e - 1] !== 1'b0 || k !== e + 36) begin
            n_fail++; $display("FAIL reset_busy: busy before=%b falls at %0d, required 0 and %0d", h_busy[e - 1], k, e + 36);
        end
    endtask

    task automatic test_single_write();
        int s0, s1, r;
        bit ok;
        restart();
        s0 = edge_cnt + 1;
        move(9'd5, 9'd0, 4'd0, 3'b000);
        wait_idle(100, ok);
        s1 = edge_cnt - 2;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_idle: busy after budget, required idle"); end
        n_checks++;
        if ({count_rises(0, s0, s1), count_rises(1, s0, s1), count_rises(2, s0, s1)} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL single_count: X=%0d Y=%0d KEY=%0d writes, required 1 0 0",
                     count_rises(0, s0, s1), count_rises(1, s0, s1), count_rises(2, s0, s1));
        end
        r = find_rise(0, s0, s1);
        n_checks++;
        if (r !== s0 + 5) begin n_fail++; $display("FAIL single_latency: MX rise at %0d, required %0d", r, s0 + 5); end
        n_checks++;
        if (h_do[r] !== 8'h05) begin n_fail++; $display("FAIL single_data: DO=%h, required 05", h_do[r]); end
        n_checks++;
        if (pulse_width(0, r) !== 4) begin n_fail++; $display("FAIL single_width: MX high %0d, required 4", pulse_width(0, r)); end
        n_checks++;
        if (stable_span(r) !== 12) begin n_fail++; $display("FAIL single_stable: DO stable %0d samples, required 12", stable_span(r)); end
    endtask

    task automatic test_wrap();
        int s0, s1, r;
        bit ok;
        restart();
        move(9'h1FE, 9'd0, 4'd0, 3'b000);
        wait_idle(100, ok);
        s0 = edge_cnt + 1;
        move(9'd3, 9'h1FF, 4'd0, 3'b000);
        wait_idle(100, ok);
        s1 = edge_cnt - 2;
        r = find_rise(0, s0, s1);
        n_checks++;
        if (r < 0 || h_do[r] !== 8'h01) begin n_fail++; $display("FAIL wrap_x: rise %0d DO=%h, required 01", r, (r < 0) ? 8'h00 : h_do[r]); end
        r = find_rise(1, s0, s1);
        n_checks++;
        if (r < 0 || h_do[r] !== 8'hFF) begin n_fail++; $display("FAIL wrap_y: rise %0d DO=%h, required ff", r, (r < 0) ? 8'h00 : h_do[r]); end
    endtask

    task automatic test_key();
        int s0, s1, r;
        bit ok;
        logic [7:0] exp;
`ifdef MOUSE_WHEEL_EN
        exp = 8'h1E;
`else
        exp = 8'hFE;
`endif
        restart();
        s0 = edge_cnt + 1;
        move(9'd0, 9'd0, 4'd2, 3'b001);
        wait_idle(100, ok);
        s1 = edge_cnt - 2;
        r = find_rise(2, s0, s1);
        n_checks++;
        if (r < 0 || h_do[r] !== exp) begin n_fail++; $display("FAIL key_byte: rise %0d DO=%h, required %h", r, (r < 0) ? 8'h00 : h_do[r], exp); end
        n_checks++;
        if (count_rises(0, s0, s1) + count_rises(1, s0, s1) !== 0) begin
            n_fail++; $display("FAIL key_only: %0d X/Y writes, required 0", count_rises(0, s0, s1) + count_rises(1, s0, s1));
        end
    endtask

    task automatic test_update_during_write();
        int s0, s1, r1, r2, r3;
        bit ok, seen;
        restart();
        s0 = edge_cnt + 1;
        move(9'd5, 9'd0, 4'd0, 3'b000);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (MX === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL mid_wait_mx: MX never high, required high"); end
        move(9'd1, 9'd3, 4'd0, 3'b000);
        wait_idle(200, ok);
        s1 = edge_cnt - 2;
        r1 = find_rise(0, s0, s1);
        r2 = find_rise(1, s0, s1);
        r3 = find_rise(0, r1 + 1, s1);
        n_checks++;
        if (r1 < 0 || h_do[r1] !== 8'h05 || stable_span(r1) !== 12) begin
            n_fail++; $display("FAIL mid_first: rise %0d stable %0d, required DO=05 stable 12", r1, stable_span(r1));
        end
        n_checks++;
        if (r2 !== r1 + 12 || h_do[r2] !== 8'h03) begin
            n_fail++; $display("FAIL mid_y: rise %0d DO=%h, required %0d and 03", r2, (r2 < 0) ? 8'h00 : h_do[r2], r1 + 12);
        end
        n_checks++;
        if (r3 !== r1 + 24 || h_do[r3] !== 8'h06) begin
            n_fail++; $display("FAIL mid_rewrite: rise %0d DO=%h, required %0d and 06", r3, (r3 < 0) ? 8'h00 : h_do[r3], r1 + 24);
        end
        n_checks++;
        if (count_rises(0, s0, s1) !== 2 || count_rises(2, s0, s1) !== 0) begin
            n_fail++; $display("FAIL mid_count: X=%0d KEY=%0d writes, required 2 0", count_rises(0, s0, s1), count_rises(2, s0, s1));
        end
    endtask

    task automatic test_reset_mid();
        int e;
        bit seen;
        restart();
        move(9'd7, 9'd9, 4'd0, 3'b000);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (MY === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rmid_wait_my: MY never high, required high"); end
        RESET = 1'b1;
        step(1);
        n_checks++;
        if ({MY, MX, MKEY, BUSY, DO} !== {4'b0000, 8'hFF}) begin
            n_fail++; $display("FAIL rmid_drop: MY=%b MX=%b MKEY=%b BUSY=%b DO=%h, required 0 0 0 0 ff", MY, MX, MKEY, BUSY, DO);
        end
        RESET = 1'b0;
        e = edge_cnt + 1;
        step(45);
        n_checks++;
        if ({find_rise(0, e, e + 40), find_rise(1, e, e + 40), find_rise(2, e, e + 40)} !== {e + 4, e + 16, e + 28}) begin
            n_fail++;
            $display("FAIL rmid_restart: rises %0d %0d %0d, required %0d %0d %0d", find_rise(0, e, e + 40),
                     find_rise(1, e, e + 40), find_rise(2, e, e + 40), e + 4, e + 16, e + 28);
        end
        n_checks++;
        if ({h_do[e + 4], h_do[e + 16], h_do[e + 28]} !== {8'h00, 8'h00, 8'hFF}) begin
            n_fail++; $display("FAIL rmid_bytes: %h %h %h, required 00 00 ff", h_do[e + 4], h_do[e + 16], h_do[e + 28]);
        end
    endtask

    task automatic test_random();
        int s0, s1, multi;
        int nwr[3];
        logic [7:0] last[3];
        logic [7:0] exp, fin;
        logic [8:0] dx, dy;
        logic [3:0] dw;
        bit ok;
        restart();
        s0 = edge_cnt + 1;
        for (int n = 0; n < 80; n++) begin
            dx = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
            dy = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
            dw = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            move(dx, dy, dw, ($urandom_range(0, 2) == 0) ? BTN : 3'($urandom));
            step($urandom_range(0, 14));
        end
        wait_idle(400, ok);
        s1 = edge_cnt - 2;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rand_idle: busy after budget, required idle"); end
        multi = 0;
        for (int w = 0; w < 3; w++) nwr[w] = 0;
        for (int k = s0; k <= s1; k++) begin
            if ($countones(h_st[k]) > 1) multi++;
            for (int w = 0; w < 3; w++) begin
                if (h_st[k][w] && !h_st[k-1][w]) begin
                    exp = (w == 0) ? h_x[k - 5] : (w == 1) ? h_y[k - 5] : h_key[k - 5];
                    n_checks++;
                    if (h_do[k] !== exp) begin n_fail++; $display("FAIL rand_data: reg %0d at %0d DO=%h, required %h", w, k, h_do[k], exp); end
                    n_checks++;
                    if (pulse_width(w, k) !== 4 || stable_span(k) !== 12) begin
                        n_fail++; $display("FAIL rand_timing: reg %0d at %0d width %0d stable %0d, required 4 12", w, k, pulse_width(w, k), stable_span(k));
                    end
                    last[w] = h_do[k];
                    nwr[w]++;
                end
            end
        end
        n_checks++;
        if (multi !== 0) begin n_fail++; $display("FAIL rand_onehot: %0d cycles with several strobes, required 0", multi); end
        for (int w = 0; w < 3; w++) begin
            fin = (w == 0) ? h_x[s1] : (w == 1) ? h_y[s1] : h_key[s1];
            if (nwr[w] > 0) begin
                n_checks++;
                if (last[w] !== fin) begin n_fail++; $display("FAIL rand_final: reg %0d last written %h, required %h", w, last[w], fin); end
            end
        end
        n_checks++;
        if (nwr[0] == 0 || nwr[1] == 0) begin n_fail++; $display("FAIL rand_activity: X=%0d Y=%0d writes, required >0", nwr[0], nwr[1]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_wrap();
        test_key();
        test_update_during_write();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
